pipe_ctrl: RTL
==============

# pipe_ctrl

Central hazard and stall controller for the 5-stage MIPS pipeline. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC:
- inserts load-use bubbles into ID/EX through its active-low clear;
- squashes the two younger instructions on a taken branch or jump resolved in EX;
- freezes the whole pipeline while a multi-cycle data-memory access is pending.

It also keeps saturating stall and flush statistics.

## Interface
Parameters:
- LOAD_USE_CYCLES, default 1: bubbles per load-use hazard; legal values 1 (EX forwarding present) or 2 (no forwarding).
- CNT_W, default 16: width of the statistics counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on negedge CLK, same edge as the pipeline registers.
- Clrn  in  1  asynchronous, active-low reset.
- D_Rs, D_Rt  in  5 each  source registers of the instruction in ID.
- D_UseRt  in  1  the ID instruction reads Rt (R-type, beq, sw).
- E_MemtoReg, E_RegWr  in  1 each  the EX instruction is a load writing a register.
- E_Rt  in  5  destination of the EX load.
- E_Taken  in  1  branch in EX resolved taken (E_Branch & zero).
- E_Jump  in  1  jump in EX.
- M_MemReq  in  1  the MEM instruction accesses data memory.
- M_MemRdy  in  1  data-memory access completes this cycle.
- PC_Wr  out  1  PC update enable.
- IFID_Wr  out  1  IF/ID load enable.
- IFID_Clrn  out  1  active-low squash of IF/ID.
- IDEX_Clrn  out  1  active-low bubble into ID/EX.
- Pipe_En  out  1  global advance enable for ID/EX, EX/MEM and MEM/WB.
- Redirect  out  1  PC mux selects the branch/jump target.
- stall_cnt  out  CNT_W  count of cycles with PC_Wr=0 while Clrn=1.
- flush_cnt  out  CNT_W  count of redirect cycles.
- state  out  2  current FSM state, for debug.

## Operation
- States are RUN=0, LDSTALL=1, MEMWAIT=2.
- A ret_state register records the state MEMWAIT returns to.
- Control outputs are combinational (Mealy) from state and inputs. State, ret_state and counters are registered.
- Load-use condition lu = E_MemtoReg & E_RegWr & (E_Rt≠0) & ((E_Rt==D_Rs) | (D_UseRt & E_Rt==D_Rt)).
- Memory-wait condition mw = M_MemReq & ~M_MemRdy.
- Default outputs: PC_Wr=IFID_Wr=IFID_Clrn=IDEX_Clrn=Pipe_En=1, Redirect=0.
- RUN, evaluated in priority order:
  1. mw: Pipe_En=PC_Wr=IFID_Wr=0. Next state MEMWAIT, ret_state=RUN.
  2. E_Taken|E_Jump: Redirect=1, IFID_Clrn=0, IDEX_Clrn=0, flush_cnt+1. Stay RUN. lu is ignored because the ID instruction is squashed.
  3. lu: PC_Wr=IFID_Wr=0, IDEX_Clrn=0. Next state is LDSTALL if LOAD_USE_CYCLES=2, otherwise RUN.
- LDSTALL:
  - mw takes priority: freeze as in RUN, next state MEMWAIT, ret_state=LDSTALL.
  - Otherwise: PC_Wr=IFID_Wr=0, IDEX_Clrn=0, next state RUN.
- MEMWAIT:
  - While M_MemRdy=0: Pipe_En=PC_Wr=IFID_Wr=0; Redirect, IDEX_Clrn and IFID_Clrn held inactive.
  - On M_MemRdy=1: outputs and next state are exactly those of ret_state evaluated with mw=0.
- Simultaneous events:
  - The frozen EX instruction's redirect or hazard is re-evaluated on exit from MEMWAIT. No event is lost.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset (Clrn=0), asynchronous:
  - state=RUN, ret_state=RUN, stall_cnt=0, flush_cnt=0;
  - outputs PC_Wr=IFID_Wr=Pipe_En=0, IFID_Clrn=IDEX_Clrn=0, Redirect=0.
- Reset asserted mid-stall or mid-wait aborts immediately. The first negedge after deassertion evaluates from RUN.
- Latency: input to output is 0 cycles (combinational), sampled by the pipeline registers at the next negedge.
- Each load-use hazard costs exactly LOAD_USE_CYCLES bubbles.
- Each redirect costs 2 squashed slots and 1 controller cycle.
- A memory wait of N cycles with M_MemRdy=0 freezes the pipeline for exactly N cycles.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum encodings RUN/LDSTALL/MEMWAIT;
  - the legal LOAD_USE_CYCLES values;
  - the register-zero constant 5'd0.
- One sub-module, lu_detect: combinational load-use comparator producing lu.
- The FSM, output decode and counters live in pipe_ctrl.

## Test plan
- Load-use: E_MemtoReg=1, E_RegWr=1, E_Rt=8, D_Rs=8, LOAD_USE_CYCLES=1 -> one cycle PC_Wr=0, IDEX_Clrn=0; stall_cnt=1.
- Same stimulus with LOAD_USE_CYCLES=2 -> two bubble cycles, state sequence RUN→LDSTALL→RUN.
- Register zero: E_Rt=0, D_Rs=0 -> no stall. D_UseRt=0 with E_Rt==D_Rt=5 -> no stall.
- Taken branch together with lu in the same cycle -> Redirect=1, IFID_Clrn=IDEX_Clrn=0, PC_Wr=1, no stall; flush_cnt=1.
- M_MemReq=1 with M_MemRdy low for 3 cycles during LDSTALL -> Pipe_En=0 for 3 cycles. Then M_MemRdy=1 -> LDSTALL output, then RUN.
- Clrn pulsed low in MEMWAIT -> state=0 and counters=0 immediately. Saturation: force 2^CNT_W−1 stalls -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall controller:
//   FSM state encodings, the legal load-use bubble counts and the
//   hardwired-zero register number.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    // Bubbles per load-use hazard: 1 when EX forwarding exists, 2 without it.
    localparam int LU_CYCLES_FWD   = 1;
    localparam int LU_CYCLES_NOFWD = 2;

    // $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_lu_detect.sv
// lu_detect
//   Combinational load-use comparator. Flags when the load in EX writes a
//   register that the instruction in ID reads.
// Ports:
//   d_rs_i, d_rt_i  source registers of the ID instruction
//   d_use_rt_i      ID instruction actually reads Rt
//   e_memtoreg_i    EX instruction is a load
//   e_regwr_i       EX instruction writes a register
//   e_rt_i          destination register of the EX load
//   lu_o            load-use hazard present
module lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] d_rs_i,
    input  logic [4:0] d_rt_i,
    input  logic       d_use_rt_i,
    input  logic       e_memtoreg_i,
    input  logic       e_regwr_i,
    input  logic [4:0] e_rt_i,
    output logic       lu_o
);

    logic is_load_wr;
    logic rs_hit;
    logic rt_hit;

    assign is_load_wr = e_memtoreg_i & e_regwr_i & (e_rt_i != REG_ZERO);
    assign rs_hit     = (e_rt_i == d_rs_i);
    // Rt only matters when the ID instruction reads it (not for lw/addi).
    assign rt_hit     = d_use_rt_i & (e_rt_i == d_rt_i);
    assign lu_o       = is_load_wr & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Hazard and stall controller for the 5-stage MIPS pipeline. Inserts
//   load-use bubbles, squashes the two younger instructions on a taken
//   branch/jump resolved in EX, and freezes the pipeline while a data-memory
//   access is pending. Keeps saturating stall and redirect statistics.
//   All state changes on the falling clock edge, like the pipeline registers.
// Ports:
//   CLK, Clrn             clock (negedge active), async active-low reset
//   D_Rs, D_Rt, D_UseRt   ID instruction sources
//   E_MemtoReg, E_RegWr,
//   E_Rt                  EX load description
//   E_Taken, E_Jump       redirect requests resolved in EX
//   M_MemReq, M_MemRdy    data-memory handshake of the MEM instruction
//   PC_Wr, IFID_Wr        PC / IF-ID load enables
//   IFID_Clrn, IDEX_Clrn  active-low squash/bubble
//   Pipe_En               advance enable for ID/EX, EX/MEM, MEM/WB
//   Redirect              PC mux selects branch/jump target
//   stall_cnt, flush_cnt  saturating statistics
//   state                 current FSM state
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = LU_CYCLES_FWD,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             Clrn,
    input  logic [4:0]       D_Rs,
    input  logic [4:0]       D_Rt,
    input  logic             D_UseRt,
    input  logic             E_MemtoReg,
    input  logic             E_RegWr,
    input  logic [4:0]       E_Rt,
    input  logic             E_Taken,
    input  logic             E_Jump,
    input  logic             M_MemReq,
    input  logic             M_MemRdy,
    output logic             PC_Wr,
    output logic             IFID_Wr,
    output logic             IFID_Clrn,
    output logic             IDEX_Clrn,
    output logic             Pipe_En,
    output logic             Redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           eval_st;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             lu;
    logic             mw;
    logic             mw_eff;
    logic             holding;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    lu_detect u_lu_detect (
        .d_rs_i       (D_Rs),
        .d_rt_i       (D_Rt),
        .d_use_rt_i   (D_UseRt),
        .e_memtoreg_i (E_MemtoReg),
        .e_regwr_i    (E_RegWr),
        .e_rt_i       (E_Rt),
        .lu_o         (lu)
    );

    assign mw = M_MemReq & ~M_MemRdy;

    always_comb begin
        PC_Wr     = 1'b1;
        IFID_Wr   = 1'b1;
        IFID_Clrn = 1'b1;
        IDEX_Clrn = 1'b1;
        Pipe_En   = 1'b1;
        Redirect  = 1'b0;
        state_d   = state_q;
        ret_d     = ret_q;
        eval_st   = state_q;
        mw_eff    = mw;
        holding   = 1'b0;

        // Leaving MEMWAIT behaves exactly like the state that was frozen,
        // so a redirect or hazard held in EX during the wait is not lost.
        if (state_q == ST_MEMWAIT) begin
            if (!M_MemRdy) begin
                holding = 1'b1;
                Pipe_En = 1'b0;
                PC_Wr   = 1'b0;
                IFID_Wr = 1'b0;
            end else begin
                eval_st = ret_q;
                mw_eff  = 1'b0;
            end
        end

        if (!holding) begin
            case (eval_st)
                ST_LDSTALL: begin
                    if (mw_eff) begin
                        Pipe_En = 1'b0;
                        PC_Wr   = 1'b0;
                        IFID_Wr = 1'b0;
                        state_d = ST_MEMWAIT;
                        ret_d   = ST_LDSTALL;
                    end else begin
                        PC_Wr     = 1'b0;
                        IFID_Wr   = 1'b0;
                        IDEX_Clrn = 1'b0;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (mw_eff) begin
                        Pipe_En = 1'b0;
                        PC_Wr   = 1'b0;
                        IFID_Wr = 1'b0;
                        state_d = ST_MEMWAIT;
                        ret_d   = ST_RUN;
                    end else if (E_Taken | E_Jump) begin
                        // ID instruction is squashed, so any load-use on it is moot.
                        Redirect  = 1'b1;
                        IFID_Clrn = 1'b0;
                        IDEX_Clrn = 1'b0;
                    end else if (lu) begin
                        PC_Wr     = 1'b0;
                        IFID_Wr   = 1'b0;
                        IDEX_Clrn = 1'b0;
                        if (LOAD_USE_CYCLES == LU_CYCLES_NOFWD) begin
                            state_d = ST_LDSTALL;
                        end
                    end
                end
            endcase
        end

        // Hold everything inert while reset is asserted.
        if (!Clrn) begin
            PC_Wr     = 1'b0;
            IFID_Wr   = 1'b0;
            IFID_Clrn = 1'b0;
            IDEX_Clrn = 1'b0;
            Pipe_En   = 1'b0;
            Redirect  = 1'b0;
        end

        stall_d = PC_Wr    ? stall_q : sat_inc(stall_q);
        flush_d = Redirect ? sat_inc(flush_q) : flush_q;
    end

    always_ff @(negedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign state     = state_q;

endmodule
